// File: rtl/reservation_station.sv
// Tomasulo reservation station feeding a single functional unit.
// Entries live in a collapsing queue (index 0 = oldest). Missing operands are
// captured from the CDB; the oldest fully-ready entry is dispatched when the
// FU is free, never on two consecutive cycles.
//
// Handshakes: an issue is taken on a posedge where issue_valid && issue_ready;
// issue_ready depends only on registered occupancy, so a dispatch in the same
// cycle never frees a slot for that cycle's issue. fu_instr_valid is a
// one-cycle pulse with no back-pressure; fu_available gates it.
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 3,
  parameter int DW    = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [DW-1:0]                issue_instr,
  input  logic [TAGW-1:0]              issue_tag,
  input  logic [DW-1:0]                issue_vj,
  input  logic [TAGW-1:0]              issue_qj,
  input  logic                         issue_qj_wait,
  input  logic [DW-1:0]                issue_vk,
  input  logic [TAGW-1:0]              issue_qk,
  input  logic                         issue_qk_wait,
  input  logic                         cdb_valid,
  input  logic [TAGW-1:0]              cdb_tag,
  input  logic [DW-1:0]                cdb_data,
  input  logic                         fu_available,
  output logic                         fu_instr_valid,
  output logic [DW-1:0]                fu_instruction,
  output logic [TAGW-1:0]              fu_tag,
  output logic [DW-1:0]                fu_reg2,
  output logic [DW-1:0]                fu_reg1,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int OCCW = $clog2(DEPTH + 1);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage
  logic [DEPTH-1:0]  busy_q, busy_d, wj_q, wj_d, wk_q, wk_d;
  logic [DW-1:0]     instr_q [DEPTH];
  logic [DW-1:0]     instr_d [DEPTH];
  logic [TAGW-1:0]   tag_q   [DEPTH];
  logic [TAGW-1:0]   tag_d   [DEPTH];
  logic [DW-1:0]     vj_q    [DEPTH];
  logic [DW-1:0]     vj_d    [DEPTH];
  logic [TAGW-1:0]   qj_q    [DEPTH];
  logic [TAGW-1:0]   qj_d    [DEPTH];
  logic [DW-1:0]     vk_q    [DEPTH];
  logic [DW-1:0]     vk_d    [DEPTH];
  logic [TAGW-1:0]   qk_q    [DEPTH];
  logic [TAGW-1:0]   qk_d    [DEPTH];
  logic [OCCW-1:0]   occupancy_q, occupancy_d;

  // Output registers
  logic              fu_instr_valid_q, fu_instr_valid_d;
  logic [DW-1:0]     fu_instruction_q, fu_instruction_d;
  logic [TAGW-1:0]   fu_tag_q, fu_tag_d;
  logic [DW-1:0]     fu_reg2_q, fu_reg2_d;
  logic [DW-1:0]     fu_reg1_q, fu_reg1_d;

  // Post-snoop view of every entry, with one extra empty slot at the top so
  // the shift-down can read index i+1 without a bounds special case.
  logic [DEPTH:0]    sn_busy, sn_wj, sn_wk;
  logic [DW-1:0]     sn_instr [DEPTH+1];
  logic [TAGW-1:0]   sn_tag   [DEPTH+1];
  logic [DW-1:0]     sn_vj    [DEPTH+1];
  logic [TAGW-1:0]   sn_qj    [DEPTH+1];
  logic [DW-1:0]     sn_vk    [DEPTH+1];
  logic [TAGW-1:0]   sn_qk    [DEPTH+1];

  logic [DEPTH-1:0]  rdy;
  logic              any_rdy, dispatch, issue_acc;
  logic [IDXW-1:0]   sel;
  logic [OCCW-1:0]   wr_idx;
  logic [IDXW:0]     src;
  logic              iss_j_hit, iss_k_hit;

  assign issue_ready    = (occupancy_q < OCCW'(DEPTH));
  assign issue_acc      = issue_valid && issue_ready;
  assign occupancy      = occupancy_q;
  assign fu_instr_valid = fu_instr_valid_q;
  assign fu_instruction = fu_instruction_q;
  assign fu_tag         = fu_tag_q;
  assign fu_reg2        = fu_reg2_q;
  assign fu_reg1        = fu_reg1_q;

  // CDB snoop applied to every busy entry; j and k match independently
  always_comb begin
    sn_busy = '0;
    sn_wj   = '0;
    sn_wk   = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      sn_instr[i] = '0;
      sn_tag[i]   = '0;
      sn_vj[i]    = '0;
      sn_qj[i]    = '0;
      sn_vk[i]    = '0;
      sn_qk[i]    = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      sn_busy[i]  = busy_q[i];
      sn_instr[i] = instr_q[i];
      sn_tag[i]   = tag_q[i];
      sn_vj[i]    = vj_q[i];
      sn_qj[i]    = qj_q[i];
      sn_wj[i]    = wj_q[i];
      sn_vk[i]    = vk_q[i];
      sn_qk[i]    = qk_q[i];
      sn_wk[i]    = wk_q[i];
      if (busy_q[i] && wj_q[i] && cdb_valid && (qj_q[i] == cdb_tag)) begin
        sn_vj[i] = cdb_data;
        sn_wj[i] = 1'b0;
      end
      if (busy_q[i] && wk_q[i] && cdb_valid && (qk_q[i] == cdb_tag)) begin
        sn_vk[i] = cdb_data;
        sn_wk[i] = 1'b0;
      end
    end
  end

  // Oldest-ready selection uses start-of-cycle state only (no CDB forwarding)
  always_comb begin
    rdy     = busy_q & ~wj_q & ~wk_q;
    any_rdy = |rdy;
    sel     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) sel = IDXW'(i);
    end
    dispatch = fu_available && !fu_instr_valid_q && any_rdy;
  end

  // Collapse the queue over the dispatched slot, then append the issued entry
  always_comb begin
    busy_d = '0;
    wj_d   = '0;
    wk_d   = '0;
    instr_d = instr_q;
    tag_d   = tag_q;
    vj_d    = vj_q;
    qj_d    = qj_q;
    vk_d    = vk_q;
    qk_d    = qk_q;
    src     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src = (dispatch && (i >= int'(sel))) ? (IDXW+1)'(i + 1) : (IDXW+1)'(i);
      busy_d[i]  = sn_busy[src];
      instr_d[i] = sn_instr[src];
      tag_d[i]   = sn_tag[src];
      vj_d[i]    = sn_vj[src];
      qj_d[i]    = sn_qj[src];
      wj_d[i]    = sn_wj[src];
      vk_d[i]    = sn_vk[src];
      qk_d[i]    = sn_qk[src];
      wk_d[i]    = sn_wk[src];
    end
    iss_j_hit = issue_qj_wait && cdb_valid && (issue_qj == cdb_tag);
    iss_k_hit = issue_qk_wait && cdb_valid && (issue_qk == cdb_tag);
    wr_idx    = occupancy_q - OCCW'(dispatch);
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_acc && (OCCW'(i) == wr_idx)) begin
        busy_d[i]  = 1'b1;
        instr_d[i] = issue_instr;
        tag_d[i]   = issue_tag;
        vj_d[i]    = iss_j_hit ? cdb_data : issue_vj;
        qj_d[i]    = issue_qj;
        wj_d[i]    = issue_qj_wait && !iss_j_hit;
        vk_d[i]    = iss_k_hit ? cdb_data : issue_vk;
        qk_d[i]    = issue_qk;
        wk_d[i]    = issue_qk_wait && !iss_k_hit;
      end
    end
    occupancy_d = occupancy_q + OCCW'(issue_acc) - OCCW'(dispatch);
  end

  // Dispatch outputs: pulse valid, hold data until the next dispatch
  always_comb begin
    fu_instr_valid_d = dispatch;
    fu_instruction_d = fu_instruction_q;
    fu_tag_d         = fu_tag_q;
    fu_reg2_d        = fu_reg2_q;
    fu_reg1_d        = fu_reg1_q;
    if (dispatch) begin
      fu_instruction_d = instr_q[sel];
      fu_tag_d         = tag_q[sel];
      fu_reg2_d        = vj_q[sel];
      fu_reg1_d        = vk_q[sel];
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q           <= '0;
      wj_q             <= '0;
      wk_q             <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        tag_q[i]   <= '0;
        vj_q[i]    <= '0;
        qj_q[i]    <= '0;
        vk_q[i]    <= '0;
        qk_q[i]    <= '0;
      end
      occupancy_q      <= '0;
      fu_instr_valid_q <= 1'b0;
      fu_instruction_q <= '0;
      fu_tag_q         <= '0;
      fu_reg2_q        <= '0;
      fu_reg1_q        <= '0;
    end else begin
      busy_q           <= busy_d;
      wj_q             <= wj_d;
      wk_q             <= wk_d;
      instr_q          <= instr_d;
      tag_q            <= tag_d;
      vj_q             <= vj_d;
      qj_q             <= qj_d;
      vk_q             <= vk_d;
      qk_q             <= qk_d;
      occupancy_q      <= occupancy_d;
      fu_instr_valid_q <= fu_instr_valid_d;
      fu_instruction_q <= fu_instruction_d;
      fu_tag_q         <= fu_tag_d;
      fu_reg2_q        <= fu_reg2_d;
      fu_reg1_q        <= fu_reg1_d;
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station (DEPTH=4, TAGW=3, DW=16).
// Inputs change 1ns after each posedge; outputs are checked at that point.
module tb_reservation_station;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [15:0] issue_instr = '0;
  logic [2:0]  issue_tag = '0;
  logic [15:0] issue_vj = '0;
  logic [2:0]  issue_qj = '0;
  logic        issue_qj_wait = 1'b0;
  logic [15:0] issue_vk = '0;
  logic [2:0]  issue_qk = '0;
  logic        issue_qk_wait = 1'b0;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;
  logic        fu_available = 1'b0;
  logic        fu_instr_valid;
  logic [15:0] fu_instruction;
  logic [2:0]  fu_tag;
  logic [15:0] fu_reg2;
  logic [15:0] fu_reg1;
  logic [2:0]  occupancy;

  int tests = 0;
  int fails = 0;

  reservation_station #(.DEPTH(4), .TAGW(3), .DW(16)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_tag(issue_tag),
    .issue_vj(issue_vj), .issue_qj(issue_qj), .issue_qj_wait(issue_qj_wait),
    .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_qk_wait(issue_qk_wait),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_available(fu_available), .fu_instr_valid(fu_instr_valid),
    .fu_instruction(fu_instruction), .fu_tag(fu_tag),
    .fu_reg2(fu_reg2), .fu_reg1(fu_reg1), .occupancy(occupancy)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] ins, input logic [2:0] tg,
                       input logic [15:0] vj, input logic [2:0] qj, input logic qjw,
                       input logic [15:0] vk, input logic [2:0] qk, input logic qkw);
    issue_valid   = 1'b1;
    issue_instr   = ins;
    issue_tag     = tg;
    issue_vj      = vj;
    issue_qj      = qj;
    issue_qj_wait = qjw;
    issue_vk      = vk;
    issue_qk      = qk;
    issue_qk_wait = qkw;
  endtask

  task automatic cdb(input logic v, input logic [2:0] tg, input logic [15:0] d);
    cdb_valid = v;
    cdb_tag   = tg;
    cdb_data  = d;
  endtask

  // Checks a dispatch pulse and its payload
  task automatic chk_disp(input string tg, input logic [15:0] ins, input logic [2:0] t,
                          input logic [15:0] r2, input logic [15:0] r1);
    chk({tg, "_valid"}, 32'(fu_instr_valid), 32'd1);
    chk({tg, "_instr"}, 32'(fu_instruction), 32'(ins));
    chk({tg, "_tag"},   32'(fu_tag),         32'(t));
    chk({tg, "_reg2"},  32'(fu_reg2),        32'(r2));
    chk({tg, "_reg1"},  32'(fu_reg1),        32'(r1));
  endtask

  initial begin
    // ---- reset state
    step();
    reset = 1'b0;
    chk("rst_occ",   32'(occupancy),      32'd0);
    chk("rst_ready", 32'(issue_ready),    32'd1);
    chk("rst_valid", 32'(fu_instr_valid), 32'd0);
    chk("rst_reg2",  32'(fu_reg2),        32'd0);

    // ---- ready add, minimum latency
    fu_available = 1'b1;
    issue(16'h0010, 3'd1, 16'd5, 3'd0, 1'b0, 16'd3, 3'd0, 1'b0);
    step();
    issue_valid = 1'b0;
    chk("add_occ1",  32'(occupancy),      32'd1);
    chk("add_nodisp", 32'(fu_instr_valid), 32'd0);
    step();
    chk_disp("add", 16'h0010, 3'd1, 16'd5, 16'd3);
    chk("add_occ0",  32'(occupancy),      32'd0);
    step();
    chk("add_pulse", 32'(fu_instr_valid), 32'd0);
    chk("add_hold",  32'(fu_reg2),        32'd5);

    // ---- CDB wakeup (with a non-matching broadcast first)
    issue(16'h0011, 3'd2, 16'd0, 3'd4, 1'b1, 16'd7, 3'd0, 1'b0);
    step();
    issue_valid = 1'b0;
    cdb(1'b1, 3'd3, 16'd99);
    step();
    cdb(1'b0, 3'd0, 16'd0);
    chk("wk_wait1", 32'(fu_instr_valid), 32'd0);
    cdb(1'b1, 3'd4, 16'd20);
    step();
    cdb(1'b0, 3'd0, 16'd0);
    chk("wk_capt_nodisp", 32'(fu_instr_valid), 32'd0);
    chk("wk_occ", 32'(occupancy), 32'd1);
    step();
    chk_disp("wk", 16'h0011, 3'd2, 16'd20, 16'd7);
    step();

    // ---- issue bypass
    issue(16'h0012, 3'd3, 16'd4, 3'd0, 1'b0, 16'd0, 3'd3, 1'b1);
    cdb(1'b1, 3'd3, 16'd9);
    step();
    issue_valid = 1'b0;
    cdb(1'b0, 3'd0, 16'd0);
    chk("byp_occ1",   32'(occupancy),      32'd1);
    chk("byp_nodisp", 32'(fu_instr_valid), 32'd0);
    step();
    chk_disp("byp", 16'h0012, 3'd3, 16'd4, 16'd9);
    chk("byp_occ0", 32'(occupancy), 32'd0);
    step();

    // ---- oldest-ready ordering, full queue
    fu_available = 1'b0;
    issue(16'h0010, 3'd6, 16'd0, 3'd5, 1'b1, 16'd1, 3'd0, 1'b0);
    step();
    issue(16'h0011, 3'd1, 16'd10, 3'd0, 1'b0, 16'd11, 3'd0, 1'b0);
    step();
    issue(16'h0012, 3'd2, 16'd20, 3'd0, 1'b0, 16'd21, 3'd0, 1'b0);
    step();
    issue(16'h001F, 3'd4, 16'd30, 3'd0, 1'b0, 16'd0, 3'd5, 1'b1);
    step();
    chk("ord_full_occ",   32'(occupancy),   32'd4);
    chk("ord_full_ready", 32'(issue_ready), 32'd0);
    issue(16'h0013, 3'd7, 16'd70, 3'd0, 1'b0, 16'd71, 3'd0, 1'b0);
    step();
    chk("ord_extra_ign", 32'(occupancy), 32'd4);
    fu_available = 1'b1;
    step();
    issue_valid = 1'b0;
    chk_disp("ord_e1", 16'h0011, 3'd1, 16'd10, 16'd11);
    chk("ord_occ3", 32'(occupancy), 32'd3);
    step();
    chk("ord_gap", 32'(fu_instr_valid), 32'd0);
    step();
    chk_disp("ord_e2", 16'h0012, 3'd2, 16'd20, 16'd21);
    chk("ord_occ2", 32'(occupancy), 32'd2);
    step();
    step();
    chk("ord_blocked", 32'(fu_instr_valid), 32'd0);
    cdb(1'b1, 3'd5, 16'd50);
    step();
    cdb(1'b0, 3'd0, 16'd0);
    chk("ord_capt_nodisp", 32'(fu_instr_valid), 32'd0);
    step();
    chk_disp("ord_e0", 16'h0010, 3'd6, 16'd50, 16'd1);
    chk("ord_occ1", 32'(occupancy), 32'd1);
    step();
    step();
    chk_disp("ord_e3", 16'h001F, 3'd4, 16'd30, 16'd50);
    chk("ord_occ0", 32'(occupancy), 32'd0);
    step();

    // ---- FU busy then release
    fu_available = 1'b0;
    issue(16'h0010, 3'd1, 16'd3, 3'd0, 1'b0, 16'd4, 3'd0, 1'b0);
    step();
    issue(16'h0011, 3'd2, 16'd6, 3'd0, 1'b0, 16'd7, 3'd0, 1'b0);
    step();
    issue_valid = 1'b0;
    step();
    step();
    chk("busy_nodisp", 32'(fu_instr_valid), 32'd0);
    chk("busy_occ",    32'(occupancy),      32'd2);
    fu_available = 1'b1;
    step();
    chk_disp("busy_a", 16'h0010, 3'd1, 16'd3, 16'd4);
    step();
    chk("busy_gap", 32'(fu_instr_valid), 32'd0);
    step();
    chk_disp("busy_b", 16'h0011, 3'd2, 16'd6, 16'd7);
    chk("busy_occ0", 32'(occupancy), 32'd0);
    step();

    // ---- reset mid-operation
    fu_available = 1'b0;
    issue(16'h0010, 3'd1, 16'd0, 3'd5, 1'b1, 16'd2, 3'd0, 1'b0);
    step();
    issue(16'h0011, 3'd2, 16'd8, 3'd0, 1'b0, 16'd9, 3'd0, 1'b0);
    step();
    issue(16'h0012, 3'd3, 16'd1, 3'd0, 1'b0, 16'd1, 3'd0, 1'b0);
    step();
    issue_valid = 1'b0;
    chk("mr_occ3", 32'(occupancy), 32'd3);
    cdb(1'b1, 3'd5, 16'd1);
    fu_available = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    cdb(1'b0, 3'd0, 16'd0);
    chk("mr_occ",   32'(occupancy),      32'd0);
    chk("mr_ready", 32'(issue_ready),    32'd1);
    chk("mr_valid", 32'(fu_instr_valid), 32'd0);
    chk("mr_instr", 32'(fu_instruction), 32'd0);
    chk("mr_tag",   32'(fu_tag),         32'd0);
    chk("mr_reg2",  32'(fu_reg2),        32'd0);
    chk("mr_reg1",  32'(fu_reg1),        32'd0);
    step();
    chk("mr_noghost", 32'(fu_instr_valid), 32'd0);
    chk("mr_occ_after", 32'(occupancy),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Tomasulo reservation station directly upstream of the functional unit.
- Accepts issued arithmetic instructions (add/sub/mul) with source operands that are either values or producer tags.
- Snoops the common data bus (CDB) for missing operands.
- Dispatches the oldest fully-ready entry to the functional unit when it is available, driving its instructIn/instruction/instructionCodeIn/reg1/reg2 inputs.

Parameters:
- DEPTH, 4: number of entries (2..8).
- TAGW, 3: tag width; matches the functional unit's instruction code width.
- DW, 16: data and instruction width.

Ports:
- clock  in  1  single system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  issue request this cycle.
- issue_ready  out  1  at least one free entry (combinational from occupancy).
- issue_instr  in  DW  instruction word; opcode in bits [3:0].
- issue_tag  in  TAGW  destination tag of the instruction.
- issue_vj  in  DW  first source value.
- issue_qj  in  TAGW  first source producer tag.
- issue_qj_wait  in  1  1 = vj not available, wait on qj.
- issue_vk  in  DW  second source value.
- issue_qk  in  TAGW  second source producer tag.
- issue_qk_wait  in  1  1 = vk not available, wait on qk.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAGW  broadcast producer tag.
- cdb_data  in  DW  broadcast result.
- fu_available  in  1  functional unit free (its disponivelUF).
- fu_instr_valid  out  1  one-cycle dispatch pulse (to instructIn).
- fu_instruction  out  DW  dispatched instruction.
- fu_tag  out  TAGW  dispatched destination tag (to instructionCodeIn).
- fu_reg2  out  DW  first operand Vj (FU computes reg2 op reg1).
- fu_reg1  out  DW  second operand Vk.
- occupancy  out  clog2(DEPTH+1)  number of busy entries.

Behaviour:
- Storage is a collapsing queue. Entry 0 is always the oldest. Each entry holds: busy, instr, tag, vj, qj, wj, vk, qk, wk.
- Reset (synchronous) clears all busy bits, occupancy=0, fu_instr_valid=0, fu_instruction=0, fu_tag=0, fu_reg1=0, fu_reg2=0.
  - Reset mid-operation discards all entries; no dispatch occurs in the reset cycle.
- Issue:
  - Accepted on a posedge with issue_valid && issue_ready.
  - issue_ready = (occupancy < DEPTH), evaluated before any same-cycle dispatch. When full, a same-cycle dispatch does not allow an issue.
  - The new entry is written at index occupancy, minus 1 if a dispatch also happens that cycle.
  - Issue bypass: if cdb_valid and a waiting source's q equals cdb_tag, that source is stored with v=cdb_data, w=0.
  - Opcodes are not checked; unsupported opcodes are stored and dispatched verbatim.
- CDB snoop: every cycle, for each busy entry and each source with w=1 and q==cdb_tag while cdb_valid, set v=cdb_data and w=0. j and k match independently; both may match the same broadcast.
- Ready rule: an entry is ready when busy && wj==0 && wk==0 at the start of the cycle. An operand captured from the CDB at edge t makes the entry dispatchable at edge t+1 at the earliest (no CDB-to-dispatch forwarding).
- Dispatch:
  - Occurs at a posedge when fu_available==1, at least one entry is ready, and fu_instr_valid==0.
  - The fu_instr_valid==0 condition forbids back-to-back dispatch, because fu_available drops one cycle late.
  - Selects the lowest-index ready entry (the oldest ready one).
  - Registers fu_instruction, fu_tag, fu_reg2=vj and fu_reg1=vk, and pulses fu_instr_valid=1 for exactly one cycle.
  - Removes the entry; younger entries shift down one index, keeping their CDB captures from the same edge.
  - fu_* data outputs hold their values until the next dispatch.
- Occupancy update = occupancy + issue_accepted - dispatched; it never exceeds DEPTH and never goes below 0.
- Minimum latency: an issue with both sources ready at edge t dispatches at edge t+1 if the FU is free.

Test Plan:
- Ready add, back-to-back:
  - Stimulus: reset; issue instr=0x0010 (add), tag=1, vj=5, vk=3, no waits; fu_available=1.
  - Required: next edge fu_instr_valid=1, fu_reg2=5, fu_reg1=3, fu_tag=1, occupancy 1->0.
- CDB wakeup:
  - Stimulus: issue sub with tag=2, qj=4 waiting, vk=7. Two cycles later, CDB tag=4 data=20.
  - Required: no dispatch before the capture; dispatch exactly one edge after capture with fu_reg2=20, fu_reg1=7.
- Issue bypass:
  - Stimulus: issue with qk=3 waiting in the same cycle as CDB tag=3 data=9.
  - Required: entry stored with vk=9; dispatch at the next edge.
- Oldest-ready ordering:
  - Stimulus: fill 4 entries where entry0 waits on tag 5 and entries 1 and 2 are ready; issue_valid=1.
  - Required: issue_ready=0 and the extra issue is ignored.
  - Required: entry1 dispatches first, then entry2 no earlier than two edges later (no back-to-back pulses).
  - Required: after CDB tag 5, entry0 dispatches.
- FU busy:
  - Stimulus: hold fu_available=0 with 2 ready entries.
  - Required: no fu_instr_valid, occupancy stays 2; on release, dispatches in age order with at least a 1-cycle gap.
- Reset mid-operation:
  - Stimulus: assert reset with 3 busy entries and a CDB broadcast pending.
  - Required: next edge occupancy=0, issue_ready=1, all fu_* outputs 0, no dispatch pulse.
